// File: rtl/sfx_sequencer.sv
// sfx_sequencer: fixed-priority arbiter and player for four sound effects.
// Each effect is a run of 16-bit tone words read from the tone BRAM's second
// port. Every word is split into four 4-bit override tones for the music
// channels. A tone of zero lets the music through.
module sfx_sequencer #(
  parameter logic [9:0]  SFX_BASE   = 10'h200,
  parameter int unsigned SFX_SLOT   = 16,
  parameter logic [31:0] STEP_TICKS = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic        cancel,
  output logic [9:0]  mem_addr,
  input  logic [15:0] mem_data,
  output logic [3:0]  t0,
  output logic [3:0]  t1,
  output logic [3:0]  t2,
  output logic [3:0]  t3,
  output logic        busy,
  output logic [1:0]  active_id,
  output logic        grant,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  pending_q, pending_d;
  logic [9:0]  mem_addr_q, mem_addr_d;
  logic [1:0]  active_id_q, active_id_d;
  logic [31:0] step_q, step_d;
  logic [31:0] tick_q, tick_d;
  logic [15:0] tones_q, tones_d;

  logic [1:0]  sel_id;
  logic [3:0]  clear_mask;

  // First word address of an effect slot. The arithmetic wraps at 10 bits.
  function automatic logic [9:0] slot_addr(input logic [1:0] id);
    return 10'(32'(SFX_BASE) + 32'(id) * SFX_SLOT);
  endfunction

  // Fixed priority: bit 0 wins.
  function automatic logic [1:0] lowest_id(input logic [3:0] p);
    casez (p)
      4'b???1: return 2'd0;
      4'b??10: return 2'd1;
      4'b?100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Next-state logic. Tones hold the previous word through FETCH and LOAD,
  // so the output never glitches to zero between words.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    active_id_d = active_id_q;
    step_d      = step_q;
    tick_d      = tick_q;
    tones_d     = tones_q;
    sel_id      = lowest_id(pending_q);
    clear_mask  = 4'b0000;

    case (state_q)
      S_IDLE: begin
        if (pending_q != 4'b0000) begin
          clear_mask  = 4'b0001 << sel_id;
          active_id_d = sel_id;
          mem_addr_d  = slot_addr(sel_id);
          step_d      = 32'd0;
          state_d     = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (mem_data == 16'h0000) begin
          tones_d = 16'h0000;
          state_d = S_DONE;
        end else begin
          tones_d = mem_data;
          tick_d  = 32'd0;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (tick_q == STEP_TICKS - 32'd1) begin
          if (step_q == SFX_SLOT - 1) begin
            // The slot is used up, so no end marker is needed.
            tones_d = 16'h0000;
            state_d = S_DONE;
          end else begin
            step_d     = step_q + 32'd1;
            mem_addr_d = mem_addr_q + 10'd1;
            state_d    = S_FETCH;
          end
        end else begin
          tick_d = tick_q + 32'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A request from the effect now playing stays latched and replays later.
    // Only the id granted in this cycle is cleared.
    pending_d = (pending_q | req) & ~clear_mask;

    // Cancel drops everything, including any req that arrives in this cycle.
    if (cancel) begin
      state_d   = S_IDLE;
      tones_d   = 16'h0000;
      pending_d = 4'b0000;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pending_q   <= 4'b0000;
      mem_addr_q  <= 10'd0;
      active_id_q <= 2'd0;
      step_q      <= 32'd0;
      tick_q      <= 32'd0;
      tones_q     <= 16'h0000;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      mem_addr_q  <= mem_addr_d;
      active_id_q <= active_id_d;
      step_q      <= step_d;
      tick_q      <= tick_d;
      tones_q     <= tones_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign active_id = active_id_q;
  assign t0        = tones_q[15:12];
  assign t1        = tones_q[11:8];
  assign t2        = tones_q[7:4];
  assign t3        = tones_q[3:0];
  assign busy      = (state_q != S_IDLE);
  assign grant     = (state_q == S_FETCH) && (step_q == 32'd0);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_sfx_sequencer.sv
// Testbench for sfx_sequencer. Stimulus is directed scenarios followed by
// random traffic. An effect-level reference model pushes the expected outputs
// for each cycle into a queue. A monitor pops that queue and compares.
module tb_sfx_sequencer;

  localparam logic [9:0] BASE = 10'h200;
  localparam int SLOT = 16;
  localparam int T    = 4;
  localparam int P    = T + 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cancel = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [9:0]  mem_addr;
  logic [15:0] mem_data;
  logic [3:0]  t0, t1, t2, t3;
  logic        busy;
  logic [1:0]  active_id;
  logic        grant;
  logic        done;

  always #5 clk = ~clk;

  logic [15:0] mem [1024];

  // Registered BRAM read port.
  always @(posedge clk) mem_data <= mem[mem_addr];

  sfx_sequencer #(
    .SFX_BASE  (BASE),
    .SFX_SLOT  (SLOT),
    .STEP_TICKS(32'(T))
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .cancel   (cancel),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .t0       (t0),
    .t1       (t1),
    .t2       (t2),
    .t3       (t3),
    .busy     (busy),
    .active_id(active_id),
    .grant    (grant),
    .done     (done)
  );

  typedef struct {
    int          cyc;
    logic        busy;
    logic        grant;
    logic        done;
    logic [1:0]  id;
    logic [9:0]  addr;
    logic        chk_addr;
    logic [15:0] tones;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc_n  = 0;

  // Reference model state, tracked per effect rather than per FSM state.
  logic [3:0]  m_pend = 4'b0000;
  bit          m_in_eff = 1'b0;
  bit          m_prev_idle = 1'b1;
  int          m_s = 0;
  int          m_D = 0;
  logic [1:0]  m_id = 2'd0;
  logic [1:0]  m_last_id = 2'd0;
  logic [15:0] m_words [16];

  // An effect that starts its first FETCH at cycle s proceeds as follows:
  // - Word k is fetched at s+k*P. Its tones appear from s+k*P+2 and stay
  //   until the next word's tones appear.
  // - With n nonzero words before a marker, done comes at s+n*P+2.
  // - A full slot of 16 nonzero words gives done at s+16*P.
  task automatic model_step(input logic [3:0] rq, input logic cn, input logic rs,
                            input int c, output exp_t e);
    int o, k, a, n;
    logic [1:0] id;
    e = '{cyc: c, busy: 1'b0, grant: 1'b0, done: 1'b0, id: m_last_id,
          addr: 10'd0, chk_addr: 1'b0, tones: 16'h0000};
    if (rs) begin
      m_pend = 4'b0000; m_in_eff = 1'b0; m_prev_idle = 1'b1; m_last_id = 2'd0;
      e.id = 2'd0; e.addr = 10'd0; e.chk_addr = 1'b1;
      return;
    end
    if (cn) begin
      m_pend = 4'b0000; m_in_eff = 1'b0; m_prev_idle = 1'b1;
      return;
    end
    if (!m_in_eff && m_prev_idle && m_pend != 4'b0000) begin
      id = 2'd0;
      for (int b = 3; b >= 0; b--) if (m_pend[b]) id = 2'(b);
      n = 16;
      for (int w = 15; w >= 0; w--) begin
        m_words[w] = mem[(int'(BASE) + int'(id) * SLOT + w) % 1024];
        if (m_words[w] == 16'h0000) n = w;
      end
      m_in_eff = 1'b1; m_s = c; m_id = id; m_last_id = id;
      m_D = (n == 16) ? 16 * P : n * P + 2;
      m_pend = (m_pend | rq) & ~(4'b0001 << id);
    end else begin
      m_pend = m_pend | rq;
    end
    if (m_in_eff) begin
      o = c - m_s;
      e.busy  = 1'b1;
      e.grant = (o == 0);
      e.done  = (o == m_D);
      e.id    = m_id;
      k = o / P;
      if (k > 15) k = 15;
      a = int'(BASE) + int'(m_id) * SLOT + k;
      e.addr = 10'(a);
      e.chk_addr = 1'b1;
      if (o >= 2 && o < m_D) e.tones = m_words[(o - 2) / P];
      if (o == m_D) m_in_eff = 1'b0;
    end
    m_prev_idle = !e.busy;
  endtask

  task automatic check(input string name, input int c, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  // Monitor: compares the DUT outputs after each edge with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("busy", e.cyc, 32'(busy), 32'(e.busy));
        check("grant", e.cyc, 32'(grant), 32'(e.grant));
        check("done", e.cyc, 32'(done), 32'(e.done));
        check("active_id", e.cyc, 32'(active_id), 32'(e.id));
        check("tones", e.cyc, 32'({t0, t1, t2, t3}), 32'(e.tones));
        if (e.chk_addr) check("mem_addr", e.cyc, 32'(mem_addr), 32'(e.addr));
      end
    end
  end

  task automatic cyc(input logic [3:0] rq, input logic cn, input logic rs);
    exp_t e;
    @(negedge clk);
    req = rq; cancel = cn; reset = rs;
    model_step(rq, cn, rs, cyc_n, e);
    sb.push_back(e);
    cyc_n++;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(4'b0000, 1'b0, 1'b0);
  endtask

  // Driver: directed scenarios, then random traffic.
  initial begin
    logic [3:0] rq;
    logic [3:0] hold_v;
    int         hold_n;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    for (int k = 0; k < 16; k++) mem[int'(BASE) + k] = 16'h8000 + 16'(k * 16'h0111);
    mem[int'(BASE) + 16] = 16'hABCD;
    mem[int'(BASE) + 17] = 16'h0F01;
    mem[int'(BASE) + 18] = 16'h5000;
    mem[int'(BASE) + 32] = 16'h1234;
    mem[int'(BASE) + 48] = 16'h00C0;
    mem[int'(BASE) + 49] = 16'h7777;

    repeat (3) cyc(4'b0000, 1'b0, 1'b1);
    // Single effect: slot 2 holds one word and then the marker.
    cyc(4'b0100, 1'b0, 1'b0);
    idle(15);
    // Two requesters at once: id 1 plays, then id 3.
    cyc(4'b1010, 1'b0, 1'b0);
    idle(45);
    // Slot 0 has no marker, so all 16 words play.
    cyc(4'b0001, 1'b0, 1'b0);
    idle(105);
    // Cancel during PLAY, with req[0] high in the same cycle.
    cyc(4'b0001, 1'b0, 1'b0);
    idle(20);
    cyc(4'b0001, 1'b1, 1'b0);
    idle(20);
    // Re-request id 0 while it is playing; it replays right after done.
    cyc(4'b0001, 1'b0, 1'b0);
    idle(10);
    cyc(4'b0001, 1'b0, 1'b0);
    idle(210);
    // Reset in the middle of PLAY.
    cyc(4'b0100, 1'b0, 1'b0);
    idle(4);
    cyc(4'b0000, 1'b0, 1'b1);
    idle(10);
    // Random traffic with occasional held levels, cancels and resets.
    hold_v = 4'b0000;
    hold_n = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_n > 0) begin
        rq = hold_v;
        hold_n--;
      end else if ($urandom_range(0, 24) == 0) begin
        rq = 4'($urandom);
        if ($urandom_range(0, 3) == 0) begin
          hold_v = rq;
          hold_n = int'($urandom_range(1, 8));
        end
      end else begin
        rq = 4'b0000;
      end
      cyc(rq, ($urandom_range(0, 199) == 0), ($urandom_range(0, 799) == 0));
    end
    idle(2);
    @(posedge clk);
    #3;
    check("scoreboard_drained", cyc_n, 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sfx_sequencer.md
Name: sfx_sequencer

Overview:
Arbitrates four sound-effect requesters and sequences the winning effect out of the shared tone BRAM's second read port. Each effect is a string of 16-bit tone words, each holding four 4-bit tones. The block presents them on t0..t3 as override tones for the music path: nonzero overrides the channel, zero passes the music tone through. It runs on the APU slow clock and replaces the single fixed-SFX oneshot.

Parameters:
SFX_BASE, 10'h200, BRAM word address of effect slot 0
SFX_SLOT, 16, words per effect slot; slot i starts at SFX_BASE + i*SFX_SLOT (10-bit wrap)
STEP_TICKS, 32'd4, clk cycles each tone word is held in PLAY (must be >= 1)

Ports:
clk  in  1  APU slow clock
reset  in  1  synchronous, active-high reset
req  in  4  per-requester play request, level or pulse, sampled every cycle; bit 0 highest priority
cancel  in  1  abort current effect and drop all pending requests
mem_addr  out  10  BRAM read address
mem_data  in  16  BRAM read data, valid 1 cycle after mem_addr
t0, t1, t2, t3  out  4 each  override tones: t0 = word[15:12], t1 = [11:8], t2 = [7:4], t3 = [3:0]
busy  out  1  high in any state except IDLE
active_id  out  2  id of the effect being played; holds its last value when IDLE
grant  out  1  one-cycle pulse, first FETCH cycle of a new effect
done  out  1  one-cycle pulse when an effect ends normally

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset: state IDLE; pending, t0..t3, mem_addr, active_id, step counter and tick counter = 0; grant, done, busy = 0.
- Pending register (4 bits):
  - Each cycle: pending <= (pending | req) & ~clear_mask.
  - clear_mask is the bit of the id granted this cycle.
  - A request from the id currently playing stays pending; it replays after done.
- IDLE:
  - If pending != 0, pick the lowest set bit as id.
  - Set active_id = id, mem_addr = SFX_BASE + id*SFX_SLOT, step = 0, then go to FETCH.
  - A req arriving in the same cycle that IDLE evaluates is not seen until the next cycle.
- FETCH: one cycle; grant = 1 only on the first FETCH of an effect; go to LOAD.
- LOAD:
  - If mem_data == 16'h0000 (end marker): tones <= 0 and go to DONE.
  - Otherwise: tones <= mem_data fields, tick = 0, go to PLAY.
- PLAY:
  - tick increments each cycle; at tick == STEP_TICKS-1 the state exits.
  - If step == SFX_SLOT-1: go to DONE with tones <= 0 (slot exhausted, no marker needed).
  - Otherwise: step += 1, mem_addr += 1, go to FETCH.
- DONE: done = 1 for one cycle; go to IDLE.
- Tone holding: tones keep the previous word through FETCH/LOAD of the next word, so there is no zero glitch between words.
- Latency:
  - req sampled at edge E0 -> grant high after E1 -> first tones valid after E3.
  - Each word occupies STEP_TICKS + 2 cycles: STEP_TICKS of PLAY, plus FETCH and LOAD.
- Arbitration: fixed priority with no preemption; a higher-priority request waits for done.
- cancel:
  - In any state, next state is IDLE.
  - tones = 0, pending = 0; no done pulse.
  - Takes precedence over req in the same cycle: that req is dropped.
  - cancel held high keeps the block in IDLE.
- Reset mid-effect: identical to the reset values above, next cycle.
- Arithmetic: address arithmetic is 10-bit and wraps modulo 1024. tick is 32 bits.

Test Plan:
- Reset then req=4'b0100 pulsed 1 cycle, slot 2 words {16'h1234, 16'h0000} -> grant after E1 with mem_addr=10'h220; t0..t3 = 1,2,3,4 after E3 for 6 cycles; then tones 0, done pulse, busy low.
- req=4'b1010 together -> id 1 plays fully (mem_addr starts 10'h210), then id 3 (10'h230); two grant and two done pulses, no gap beyond one IDLE cycle.
- Slot 0 filled with 16 nonzero words, no marker -> exactly 16 words of 4 ticks each, then done; mem_addr never reaches 10'h210.
- cancel asserted in PLAY, with req[0] also high that cycle -> tones 0 next cycle, no done, busy low, req[0] not replayed.
- req[0] re-pulsed while id 0 is playing -> id 0 replays immediately after its done; also check reset asserted mid-PLAY returns every output to 0.
